// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Provides:
//   WIDTH_DEF  default operand/result width
//   cnt_w()    iteration counter width for a given operand width
//   CNT_W      counter width at the default width
//   INT_MIN    most negative value at the default width
//   state_t    controller state encoding
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;

    // Counter must hold WIDTH without wrapping.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_w(WIDTH_DEF);

    localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

endpackage

// File: rtl/multdiv_iter_addsub_cla.sv
// addsub_cla: N-bit add/subtract with a parallel-prefix carry network.
// The Booth accumulate step and the restoring-division trial subtraction
// both use it.
// Ports:
//   a, b  operands (N bits)
//   sub   0: sum = a + b, 1: sum = a - b
//   sum   result (N bits, carry out dropped)
module addsub_cla #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    logic [N-1:0] bb;
    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] pp;
    logic [N-1:0] c;

    always_comb begin
        bb = b ^ {N{sub}};
        p  = a ^ bb;
        g  = a & bb;
        // Fold the carry-in into bit 0's generate so the prefix tree
        // directly yields the carry out of every bit.
        g[0] = g[0] | (p[0] & sub);
        pp   = p;
        // Kogge-Stone levels. Walking i downwards lets each bit read the
        // previous level's value of bit i-d before it is overwritten.
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = N - 1; i >= d; i--) begin
                g[i]  = g[i] | (pp[i] & g[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        c   = {g[N-2:0], sub};
        sum = p ^ c;
    end

endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply (radix-2 Booth) and divide
// (sign-magnitude restoring). One iteration per clock edge, WIDTH
// iterations per operation. Result and exception appear together with
// a one-cycle data_resultRDY pulse WIDTH edges after the start edge.
// Ports:
//   clock, reset_n    rising-edge clock, synchronous active-low reset
//   data_operandA/B   operands, latched on the start edge
//   ctrl_MULT/DIV     one-cycle start pulses (both high: ignored)
//   data_result       product low half or truncated quotient (held)
//   data_exception    overflow / divide-by-zero (held)
//   data_resultRDY    one-cycle completion pulse
//   busy              operation in flight
//
// state | meaning
// IDLE  | no operation in flight, outputs hold last result
// MUL   | Booth multiply iterating
// DIV   | restoring divide iterating
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam int PW = 2 * WIDTH + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] opnd, opnd_n;    // multiplicand, or |divisor|
    logic [PW-1:0]    prod, prod_n;    // {acc, multiplier, booth bit}
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] quo, quo_n;      // dividend shifts out as quotient shifts in
    logic             q_neg, q_neg_n;
    logic             b_zero, b_zero_n;
    logic             d_ovf, d_ovf_n;
    logic [WIDTH-1:0] result_n;
    logic             exc_n, rdy_n, busy_n;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic             start_mul, start_div, last;

    logic [WIDTH:0]   add_x, add_y, add_s;
    logic             add_sub;

    logic [PW-1:0]    booth_next;
    logic             mul_ovf;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next, quo_next, quo_signed;

    assign a_abs     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_abs     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign start_mul = ctrl_MULT & ~ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign last      = (cnt == CW'(WIDTH - 1));

    // Operand selection for the shared adder.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        case (state)
            MUL: begin
                add_x   = {prod[PW-1], prod[PW-1:WIDTH+1]};
                add_y   = (prod[1] ^ prod[0]) ? {opnd[WIDTH-1], opnd} : '0;
                add_sub = prod[1] & ~prod[0];
            end
            DIV: begin
                add_x   = {rem, quo[WIDTH-1]};
                add_y   = {1'b0, opnd};
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    addsub_cla #(.N(WIDTH + 1)) u_addsub (
        .a   (add_x),
        .b   (add_y),
        .sub (add_sub),
        .sum (add_s)
    );

    // Accumulator is kept one bit wider than WIDTH, so dropping that sum
    // above the multiplier bits is the arithmetic right shift.
    assign booth_next = {add_s, prod[WIDTH:1]};
    assign mul_ovf    = booth_next[PW-1:WIDTH+1] != {WIDTH{booth_next[WIDTH]}};

    assign trial_ok   = ~add_s[WIDTH];
    assign rem_next   = trial_ok ? add_s[WIDTH-1:0] : add_x[WIDTH-1:0];
    assign quo_next   = {quo[WIDTH-2:0], trial_ok};
    assign quo_signed = q_neg ? -quo_next : quo_next;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        opnd_n   = opnd;
        prod_n   = prod;
        rem_n    = rem;
        quo_n    = quo;
        q_neg_n  = q_neg;
        b_zero_n = b_zero;
        d_ovf_n  = d_ovf;
        result_n = data_result;
        exc_n    = data_exception;
        rdy_n    = 1'b0;
        busy_n   = busy;

        // A start always wins, which also aborts any operation in flight.
        if (start_mul) begin
            state_n = MUL;
            cnt_n   = '0;
            busy_n  = 1'b1;
            opnd_n  = data_operandA;
            prod_n  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        end else if (start_div) begin
            state_n  = DIV;
            cnt_n    = '0;
            busy_n   = 1'b1;
            opnd_n   = b_abs;
            rem_n    = '0;
            quo_n    = a_abs;
            q_neg_n  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            b_zero_n = (data_operandB == '0);
            d_ovf_n  = (data_operandA == MIN_NEG) && (data_operandB == '1);
        end else begin
            case (state)
                MUL: begin
                    prod_n = booth_next;
                    cnt_n  = cnt + 1'b1;
                    if (last) begin
                        state_n  = IDLE;
                        busy_n   = 1'b0;
                        rdy_n    = 1'b1;
                        result_n = booth_next[WIDTH:1];
                        exc_n    = mul_ovf;
                    end
                end
                DIV: begin
                    rem_n = rem_next;
                    quo_n = quo_next;
                    cnt_n = cnt + 1'b1;
                    if (last) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        rdy_n   = 1'b1;
                        if (b_zero) begin
                            result_n = '0;
                            exc_n    = 1'b1;
                        end else if (d_ovf) begin
                            result_n = MIN_NEG;
                            exc_n    = 1'b1;
                        end else begin
                            result_n = quo_signed;
                            exc_n    = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            opnd           <= '0;
            prod           <= '0;
            rem            <= '0;
            quo            <= '0;
            q_neg          <= 1'b0;
            b_zero         <= 1'b0;
            d_ovf          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            opnd           <= opnd_n;
            prod           <= prod_n;
            rem            <= rem_n;
            quo            <= quo_n;
            q_neg          <= q_neg_n;
            b_zero         <= b_zero_n;
            d_ovf          <= d_ovf_n;
            data_result    <= result_n;
            data_exception <= exc_n;
            data_resultRDY <= rdy_n;
            busy           <= busy_n;
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: the stimulus pushes hand-computed
// results with their expected completion edge; a monitor pops and
// compares on every RDY pulse.
module tb_multdiv_iter;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_iter #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at;
        string       nm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (data_resultRDY === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy: got RDY at edge %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk({e.nm, "_result"}, data_result, e.res);
                chk({e.nm, "_exception"}, {31'b0, data_exception}, {31'b0, e.exc});
                chk({e.nm, "_rdy_edge"}, cyc, e.at);
            end
        end
    end

    // Called just after a rising edge; returns just after the start edge.
    task automatic start_op(input string nm, input bit mul, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res,
                            input logic exc, input bit expect_done);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        if (expect_done) q.push_back('{res, exc, cyc + 32, nm});
        chk({nm, "_busy_e0"}, {31'b0, busy}, 32'd1);
        chk({nm, "_rdy_e0"}, {31'b0, data_resultRDY}, 32'd0);
    endtask

    task automatic finish_op(input string nm);
        repeat (31) @(posedge clock);
        #1;
        chk({nm, "_busy_e31"}, {31'b0, busy}, 32'd1);
        @(posedge clock);
        #1;
        chk({nm, "_busy_e32"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run(input string nm, input bit mul, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic exc);
        start_op(nm, mul, a, b, res, exc, 1'b1);
        finish_op(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("reset_result", data_result, 32'h0);
        chk("reset_exception", {31'b0, data_exception}, 32'd0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run("mul_3_m7", 1'b1, 32'd3, -32'sd7, 32'hFFFF_FFEB, 1'b0);
        @(posedge clock);
        #1;
        chk("mul_3_m7_rdy_e33", {31'b0, data_resultRDY}, 32'd0);
        chk("mul_3_m7_hold", data_result, 32'hFFFF_FFEB);

        // Back-to-back: each start lands on the previous RDY-high cycle.
        run("mul_ovf_2p16", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run("mul_m1_intmin", 1'b1, 32'hFFFF_FFFF, INT_MIN, 32'h8000_0000, 1'b1);
        run("mul_intmin_1", 1'b1, INT_MIN, 32'd1, 32'h8000_0000, 1'b0);
        run("mul_m6_m7", 1'b1, -32'sd6, -32'sd7, 32'd42, 1'b0);
        run("div_m100_7", 1'b0, -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0);
        run("div_100_m7", 1'b0, 32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0);
        run("div_7_m100", 1'b0, 32'd7, -32'sd100, 32'h0, 1'b0);
        run("div_intmin_1", 1'b0, INT_MIN, 32'd1, 32'h8000_0000, 1'b0);
        run("div_5_0", 1'b0, 32'd5, 32'd0, 32'h0, 1'b1);
        run("div_intmin_m1", 1'b0, INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Abort: multiply replaced by a divide at E10, RDY only at E42.
        start_op("abort_mul", 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        run("abort_div", 1'b0, 32'd84, 32'd4, 32'd21, 1'b0);

        // Both start pulses together from IDLE: ignored.
        data_operandA = 32'd1;
        data_operandB = 32'd1;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        chk("both_ctrl_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        chk("both_ctrl_busy_later", {31'b0, busy}, 32'd0);

        // Reset at E15 of a multiply; no RDY for it afterwards.
        start_op("rst_mul", 1'b1, 32'd5, 32'd5, 32'd25, 1'b0, 1'b0);
        chk("hold_on_start", data_result, 32'd21);
        repeat (14) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("midop_reset_result", data_result, 32'h0);
        chk("midop_reset_exception", {31'b0, data_exception}, 32'd0);
        chk("midop_reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("midop_reset_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        chk("post_reset_idle_busy", {31'b0, busy}, 32'd0);

        run("post_rst_mul", 1'b1, 32'd1000, -32'sd3, 32'hFFFF_F448, 1'b0);

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outstanding results expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
